sim_video_src: RTL and testbench
================================

// Module: sim_video_src
// PURPOSE
//  Simulation video source: an AXI4-Stream master that emits raster frames of a
//  deterministic test pattern. Sits at the head of a video pipeline in sim/bring-up
//  benches and feeds downstream stream consumers. vtlast marks end-of-line.
//  Generation is gated by a level-sensitive start input.
// PARAMETERS
//  DATA_WIDTH  24  pixel width in bits; must be >= 24 (bits above 23 driven 0)
//  H_ACTIVE    16  pixels per line (>= 1)
//  V_ACTIVE    8   lines per frame (>= 1)
//  FRAME_GAP   4   idle cycles between frames (0 = back-to-back)
//  NUM_FRAMES  0   frames to emit per start session; 0 = unlimited
// PORTS
//  clk     in   1           clock; all logic on rising edge
//  rst     in   1           reset, asynchronous, active-high
//  start   in   1           level enable; 1 = generate frames
//  vtvalid out  1           stream valid
//  vtdata  out  DATA_WIDTH  pixel {frame[7:0], y[7:0], x[7:0]}, zero-extended
//  vtlast  out  1           high on last pixel of each line (x == H_ACTIVE-1)
//  vtready in   1           downstream ready
// BEHAVIOUR
//  - rst=1: state IDLE immediately (async); vtvalid=0, vtdata=0, vtlast=0,
//    x=y=0, frame=0, gap and frame counters 0. Reset mid-frame aborts frame.
//  - All outputs registered. Beat transfers on rising edge with vtvalid&vtready.
//  - States: IDLE, ACTIVE, GAP, DONE.
//  - IDLE: on edge with start=1 -> ACTIVE, vtvalid=1, pixel (0,0) of current frame
//    presented at that edge (vtvalid rises one cycle after start first sampled high).
//  - ACTIVE: while vtvalid&!vtready, vtdata/vtlast/vtvalid held stable (no drops,
//    no changes). On transfer: x++; at x==H_ACTIVE-1 x->0, y++; next pixel shown
//    the same edge (one beat per cycle when vtready held high, no bubbles).
//  - Transfer of last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1): frame++ (wraps mod 2^8
//    in vtdata, counter itself 16 bits), x=y=0, vtvalid=0; then
//      NUM_FRAMES!=0 and frames sent == NUM_FRAMES -> DONE;
//      else FRAME_GAP>0 -> GAP; else start=1 -> next frame pixel (0,0) with
//      vtvalid kept 1; else -> IDLE.
//  - GAP: vtvalid=0 for exactly FRAME_GAP cycles, then start=1 -> ACTIVE (as IDLE),
//    start=0 -> IDLE.
//  - start deasserted mid-frame: current frame completes (no truncation); stop at
//    next frame boundary.
//  - DONE: vtvalid=0 until start=0 sampled, then IDLE with sent-frame count cleared;
//    frame index (pattern) keeps counting across sessions; only rst clears it.
//  - vtlast = 1 exactly when presented pixel has x==H_ACTIVE-1; H_ACTIVE=1 means
//    vtlast on every beat.
//  - vtready ignored when vtvalid=0; vtvalid never depends combinationally on
//    vtready.
// TESTING
//  1 Reset: rst=1 for 5 cycles -> vtvalid=0, vtdata=0, vtlast=0; start=0 after
//    release -> vtvalid stays 0.
//  2 Backpressure: start=1, vtready=0 for 10 cycles -> vtvalid=1, vtdata=0x000000
//    held all 10 cycles; then vtready=1 -> 0x000000,0x000001,0x000002 on
//    consecutive cycles.
//  3 Toggling ready (1 for 3, 0 for 1, 1 for 1, 0 for 1, 1) -> beats in strict
//    order x=0,1,2,3,4,... no repeats/skips; data stable while stalled.
//  4 Line end: vtready=1 -> vtlast=1 only on x=15 (vtdata 0x00000F), next beat
//    0x000100; 128 beats per frame with 8 vtlast pulses.
//  5 Frame boundary: after beat 0x00070F, vtvalid=0 for exactly 4 cycles, then
//    0x010000 with vtlast=0.
//  6 start=0 mid-frame -> frame finishes (ends with 0x00070F), then vtvalid=0
//    stays low; rst mid-frame -> vtvalid=0 without a clock edge.

Source files
------------

// File: rtl/sim_video_src.sv
// Simulation video source: AXI4-Stream master emitting raster frames of a
// {frame, y, x} test pattern, gated by a level-sensitive start input.
module sim_video_src #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 16,
    parameter int V_ACTIVE   = 8,
    parameter int FRAME_GAP  = 4,
    parameter int NUM_FRAMES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  vtvalid,
    output logic [DATA_WIDTH-1:0] vtdata,
    output logic                  vtlast,
    input  logic                  vtready
);

    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [XW-1:0]    X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [15:0]             frame_q, frame_d;
    logic [15:0]             sent_q, sent_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;

    logic        fire;
    logic        frame_end;
    logic [15:0] sent_inc;
    logic        quota_hit;

    assign fire      = valid_q & vtready;
    assign frame_end = fire && (x_q == X_LAST) && (y_q == Y_LAST);
    assign sent_inc  = sent_q + 16'd1;
    assign quota_hit = (NUM_FRAMES != 0) && (sent_inc == 16'(NUM_FRAMES));

    assign vtvalid = valid_q;
    assign vtdata  = data_q;
    assign vtlast  = last_q;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Next-state selection; frames always finish before start is re-examined.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (frame_end) begin
                    if (quota_hit)          state_d = S_DONE;
                    else if (FRAME_GAP > 0) state_d = S_GAP;
                    else if (start)         state_d = S_ACTIVE;
                    else                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = start ? S_ACTIVE : S_IDLE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Raster counters and the registered stream outputs for the next cycle.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        sent_d  = sent_q;
        gap_d   = '0;

        if (state_q == S_ACTIVE && fire) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 16'd1;
                    sent_d  = sent_inc;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        if (state_q == S_GAP) gap_d = gap_q + GAP_W'(1);

        // A new session starts counting its frame quota from zero.
        if (state_d == S_IDLE) sent_d = '0;

        // Stalled beats keep the same x/y, so the presented pixel holds.
        valid_d = (state_d == S_ACTIVE);
        data_d  = '0;
        last_d  = 1'b0;
        if (valid_d) begin
            data_d = DATA_WIDTH'({frame_d[7:0], 8'(y_d), 8'(x_d)});
            last_d = (x_d == X_LAST);
        end
    end

endmodule

// File: tb/tb_sim_video_src.sv
// Self-checking bench for sim_video_src with default parameters (16x8, gap 4).
module tb_sim_video_src;

    localparam int DW = 24;
    localparam int HA = 16;
    localparam int VA = 8;
    localparam int FG = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          vtvalid;
    logic [DW-1:0] vtdata;
    logic          vtlast;
    logic          vtready;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        valid;
        logic [23:0] data;
        logic        last;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic        last;
    } beat_t;

    vec_t  vecs[20];
    beat_t exp_q[$];
    int    exp_lasts;
    int    got_lasts;

    sim_video_src #(
        .DATA_WIDTH(DW),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .FRAME_GAP (FG),
        .NUM_FRAMES(0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .vtvalid(vtvalid),
        .vtdata (vtdata),
        .vtlast (vtlast),
        .vtready(vtready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int y, input int x);
        return {8'(f), 8'(y), 8'(x)};
    endfunction

    // Queue the expected beats of frame f starting at raster position (x0, y0).
    task automatic push_frame(input int f, input int x0, input int y0);
        beat_t b;
        for (int y = y0; y < VA; y++) begin
            for (int x = ((y == y0) ? x0 : 0); x < HA; x++) begin
                b.data = pix(f, y, x);
                b.last = (x == HA - 1);
                if (b.last) exp_lasts++;
                exp_q.push_back(b);
            end
        end
    endtask

    // Drive vtready each cycle and score every transferred beat against exp_q.
    // Inter-frame idle runs are checked for length; after the queue drains the
    // stream is watched for `drain` more cycles for unexpected beats.
    task automatic stream(input int budget, input bit rand_ready,
                          input int drop_start_after, input int drain);
        int    beats;
        int    low_run;
        int    extra;
        bit    seen_valid;
        bit    r;
        beat_t e;
        beats      = 0;
        low_run    = 0;
        extra      = drain;
        seen_valid = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) begin
                if (extra == 0) break;
                extra--;
            end
            r       = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            vtready = r;
            if (vtvalid) begin
                if (seen_valid && low_run > 0) check("gap_len", low_run, FG);
                low_run    = 0;
                seen_valid = 1'b1;
                if (r) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", vtdata, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", vtdata, e.data);
                        check("beat_last", vtlast, e.last);
                    end
                    if (vtlast) got_lasts++;
                    beats++;
                    if (beats == drop_start_after) start = 1'b0;
                end
            end else begin
                low_run++;
            end
            @(posedge clk);
            #1;
        end
        check("stream_pending", exp_q.size(), 0);
    endtask

    initial begin
        // Vector table: inputs for one edge, outputs expected just after it.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 24'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h0, 1'b0};
        for (int i = 2; i < 12; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 24'h0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 24'h1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 24'h2, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 24'h3, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 24'h3, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 24'h4, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 24'h4, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 24'h5, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 24'h6, 1'b0};
        exp_lasts = 0;
        got_lasts = 0;

        // Reset held for five cycles.
        rst     = 1'b1;
        start   = 1'b0;
        vtready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", vtvalid, 0);
        check("rst_data", vtdata, 0);
        check("rst_last", vtlast, 0);
        rst = 1'b0;

        // Idle, backpressure hold, then toggling ready.
        for (int i = 0; i < 20; i++) begin
            start   = vecs[i].start;
            vtready = vecs[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), vtvalid, vecs[i].valid);
            check($sformatf("vec%0d_data", i), vtdata, vecs[i].data);
            check($sformatf("vec%0d_last", i), vtlast, vecs[i].last);
        end

        // Rest of frame 0 and frames 1..2 under random backpressure.
        push_frame(0, 6, 0);
        push_frame(1, 0, 0);
        push_frame(2, 0, 0);
        stream(3000, 1'b1, 0, 0);

        // Frame 3: start dropped mid-frame, frame must finish then stay idle.
        push_frame(3, 0, 0);
        stream(1500, 1'b1, 5, 30);
        check("stop_valid", vtvalid, 0);
        check("last_count", got_lasts, exp_lasts);

        // Frame 4 restart, then asynchronous reset mid-frame.
        start   = 1'b1;
        vtready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("restart_data", vtdata, pix(4, 1, 3));
        check("restart_valid", vtvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", vtvalid, 0);
        check("async_rst_data", vtdata, 0);
        check("async_rst_last", vtlast, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", vtvalid, 1);
        check("post_rst_data", vtdata, pix(0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
